// File: rtl/count_sched_pkg.sv
// Shared definitions for the count_sched shared-counter scheduler:
// FSM state encoding and default geometry.
package count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEF    = 4;
    localparam int NREQ_DEF = 4;

endpackage

// File: rtl/count_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping modulo NREQ. Returns a one-hot winner and a valid flag.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] win,
    output logic            valid
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        win   = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // One extra bit keeps the wrap correct for non-power-of-two NREQ.
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!valid && req[idx]) begin
                win[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_sched.sv
// Shared-counter scheduler: round-robin grants one requester at a time a
// counting interval of len+1 cycles, then pulses done to that requester.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] len,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [N-1:0]      cnt_Q,
    output logic [NREQ-1:0]   done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [N-1:0]    cnt_q, cnt_d;
    logic [N-1:0]    tc_q, tc_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] win;
    logic            win_vld;
    logic [N-1:0]    len_sel;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   nxt_ptr;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .win    (win),
        .valid  (win_vld)
    );

    always_comb begin
        len_sel = '0;
        gidx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                len_sel = len_sel | len[i*N +: N];
            end
            if (grant_q[i]) begin
                gidx = PW'(i);
            end
        end
        nxt_ptr = (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
    end

    // The pointer advances as the interval ends, so the arbitration made on
    // the DONE edge already sees the finished requester as lowest priority.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        cnt_d    = cnt_q;
        tc_d     = tc_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE, DONE: begin
                if (win_vld) begin
                    grant_d = win;
                    tc_d    = len_sel;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            RUN: begin
                if ((req & grant_q) == '0) begin
                    grant_d  = '0;
                    cnt_d    = '0;
                    rr_ptr_d = nxt_ptr;
                    state_d  = IDLE;
                end else if (cnt_q == tc_q) begin
                    done_d   = grant_q;
                    grant_d  = '0;
                    cnt_d    = '0;
                    rr_ptr_d = nxt_ptr;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            cnt_q    <= '0;
            tc_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            tc_q     <= tc_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign cnt_Q = cnt_q;
    assign busy  = |grant_q;

endmodule

// File: tb/tb_count_sched.sv
// Directed self-checking bench for count_sched (N=4, NREQ=4).
module tb_count_sched;

    localparam int N    = 4;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] len;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [N-1:0]      cnt_Q;
    logic [NREQ-1:0]   done;
    logic [12:0]       obs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    count_sched #(.N(N), .NREQ(NREQ)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .len     (len),
        .grant   (grant),
        .busy    (busy),
        .cnt_Q   (cnt_Q),
        .done    (done)
    );

    // {grant, busy, cnt_Q, done}
    assign obs = {grant, busy, cnt_Q, done};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req     = '0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b1111;
        len     = 16'h1111;
        step();
        checks++;
        if (obs !== 13'b0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obs, 13'b0);
        end
        req     = '0;
        reset_n = 1'b1;
        step();
        checks++;
        if (obs !== 13'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", obs, 13'b0);
        end
    endtask

    task automatic test_single();
        apply_reset();
        len = 16'h0003;
        req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (obs !== {4'b0001, 1'b1, 4'(k), 4'b0000}) begin
                errors++;
                $display("FAIL single_run k=%0d: got %b expected %b", k, obs, {4'b0001, 1'b1, 4'(k), 4'b0000});
            end
        end
        step();
        checks++;
        if (obs !== {4'b0000, 1'b0, 4'd0, 4'b0001}) begin
            errors++;
            $display("FAIL single_done: got %b expected %b", obs, {4'b0000, 1'b0, 4'd0, 4'b0001});
        end
        req = '0;
        step();
        checks++;
        if (obs !== 13'b0) begin
            errors++;
            $display("FAIL single_idle: got %b expected %b", obs, 13'b0);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        apply_reset();
        len = 16'h1111;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            e = 4'(1 << (g % 4));
            for (int k = 0; k < 2; k++) begin
                step();
                checks++;
                if (obs !== {e, 1'b1, 4'(k), 4'b0000}) begin
                    errors++;
                    $display("FAIL rr_grant g=%0d k=%0d: got %b expected %b", g, k, obs, {e, 1'b1, 4'(k), 4'b0000});
                end
            end
            step();
            checks++;
            if (obs !== {4'b0000, 1'b0, 4'd0, e}) begin
                errors++;
                $display("FAIL rr_done g=%0d: got %b expected %b", g, obs, {4'b0000, 1'b0, 4'd0, e});
            end
        end
        req = '0;
        step();
        checks++;
        if (obs !== 13'b0) begin
            errors++;
            $display("FAIL rr_idle: got %b expected %b", obs, 13'b0);
        end
    endtask

    task automatic test_len_bounds();
        apply_reset();
        len = 16'h0000;
        req = 4'b0001;
        step();
        checks++;
        if (obs !== {4'b0001, 1'b1, 4'd0, 4'b0000}) begin
            errors++;
            $display("FAIL len0_grant: got %b expected %b", obs, {4'b0001, 1'b1, 4'd0, 4'b0000});
        end
        step();
        checks++;
        if (obs !== {4'b0000, 1'b0, 4'd0, 4'b0001}) begin
            errors++;
            $display("FAIL len0_done: got %b expected %b", obs, {4'b0000, 1'b0, 4'd0, 4'b0001});
        end
        req = '0;
        step();
        len = 16'h000F;
        req = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if (obs !== {4'b0001, 1'b1, 4'(k), 4'b0000}) begin
                errors++;
                $display("FAIL len15_run k=%0d: got %b expected %b", k, obs, {4'b0001, 1'b1, 4'(k), 4'b0000});
            end
        end
        step();
        checks++;
        if (obs !== {4'b0000, 1'b0, 4'd0, 4'b0001}) begin
            errors++;
            $display("FAIL len15_done: got %b expected %b", obs, {4'b0000, 1'b0, 4'd0, 4'b0001});
        end
        req = '0;
        step();
    endtask

    task automatic test_abort();
        apply_reset();
        len = 16'h002A;
        req = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (obs !== {4'b0001, 1'b1, 4'(k), 4'b0000}) begin
                errors++;
                $display("FAIL abort_run k=%0d: got %b expected %b", k, obs, {4'b0001, 1'b1, 4'(k), 4'b0000});
            end
        end
        req = 4'b0010;
        step();
        checks++;
        if (obs !== 13'b0) begin
            errors++;
            $display("FAIL abort_cycle: got %b expected %b", obs, 13'b0);
        end
        step();
        checks++;
        if (obs !== {4'b0010, 1'b1, 4'd0, 4'b0000}) begin
            errors++;
            $display("FAIL abort_next_grant: got %b expected %b", obs, {4'b0010, 1'b1, 4'd0, 4'b0000});
        end
        req = '0;
        step();
        checks++;
        if (obs !== 13'b0) begin
            errors++;
            $display("FAIL abort_req1: got %b expected %b", obs, 13'b0);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        len = 16'h00A0;
        req = 4'b0100;
        step();
        step();
        checks++;
        if (obs !== {4'b0000, 1'b0, 4'd0, 4'b0100}) begin
            errors++;
            $display("FAIL rmid_pre_done: got %b expected %b", obs, {4'b0000, 1'b0, 4'd0, 4'b0100});
        end
        req = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (obs !== {4'b0010, 1'b1, 4'(k), 4'b0000}) begin
                errors++;
                $display("FAIL rmid_run k=%0d: got %b expected %b", k, obs, {4'b0010, 1'b1, 4'(k), 4'b0000});
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 13'b0) begin
            errors++;
            $display("FAIL rmid_async: got %b expected %b", obs, 13'b0);
        end
        req = 4'b1100;
        step();
        checks++;
        if (obs !== 13'b0) begin
            errors++;
            $display("FAIL rmid_hold: got %b expected %b", obs, 13'b0);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (obs !== {4'b0100, 1'b1, 4'd0, 4'b0000}) begin
            errors++;
            $display("FAIL rmid_restart: got %b expected %b", obs, {4'b0100, 1'b1, 4'd0, 4'b0000});
        end
        req = '0;
        step();
    endtask

    task automatic test_len_change();
        apply_reset();
        len = 16'h0002;
        req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (obs !== {4'b0001, 1'b1, 4'(k), 4'b0000}) begin
                errors++;
                $display("FAIL lchg_run k=%0d: got %b expected %b", k, obs, {4'b0001, 1'b1, 4'(k), 4'b0000});
            end
            len = 16'h0007;
        end
        step();
        checks++;
        if (obs !== {4'b0000, 1'b0, 4'd0, 4'b0001}) begin
            errors++;
            $display("FAIL lchg_done: got %b expected %b", obs, {4'b0000, 1'b0, 4'd0, 4'b0001});
        end
        req = '0;
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        len     = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_len_bounds();
        test_abort();
        test_reset_mid();
        test_len_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
